// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : hazard_ctrl_pkg
//  Brief  : Shared constants and helpers for the hazard/forwarding controller.
//  Rev    : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Forward-select encoding: 0 reads the regfile, k reads the stage-k result
    localparam int FWD_RF = 0;
    localparam int STG_X  = 1;
    localparam int STG_M  = 2;
    localparam int STG_W  = 3;

    typedef struct packed {
        logic valid;
        logic we;
        logic is_load;
    } sb_flags_t;

    // A producer at decode-time entry k sits at k+1 once the consumer reaches X;
    // the oldest entry retires through the write-through regfile instead.
    function automatic int unsigned fwd_sel_of(input logic hit,
                                               input int unsigned k,
                                               input int unsigned depth);
        if (hit && (k < depth)) begin
            return k + 1;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module : hazard_ctrl_fwd_match
//  Brief  : Finds the youngest in-flight writer of one source register.
//  Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl_fwd_match #(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5,
    parameter int SELW  = 2
) (
    input  logic [RA_W-1:0]       rs,
    input  logic                  used,
    input  logic [DEPTH-1:0]      sb_valid,
    input  logic [DEPTH-1:0]      sb_we,
    input  logic [DEPTH-1:0]      sb_load,
    input  logic [DEPTH*RA_W-1:0] sb_rd,
    output logic                  hit,
    output logic [SELW-1:0]       idx,
    output logic                  is_load
);

    // Scan oldest to youngest so the smallest index is the one left standing
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && (rs != '0) && sb_valid[k-1] && sb_we[k-1] &&
                (sb_rd[(k-1)*RA_W +: RA_W] == rs)) begin
                hit     = 1'b1;
                idx     = SELW'(k);
                is_load = sb_load[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : hazard_ctrl
//  Brief  : Scoreboard-based forwarding selects, load-use stalls and redirect kills.
//  Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int NSRC        = 2,
    parameter int LOAD_STAGE  = 3,
    parameter int KILL_CYCLES = 1,
    parameter int RA_W        = 5,
    parameter int SELW        = $clog2(DEPTH+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_ext,
    input  logic                 id_valid,
    input  logic [NSRC*RA_W-1:0] id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [RA_W-1:0]      id_rd,
    input  logic                 id_we,
    input  logic                 id_is_load,
    input  logic                 redirect,
    output logic                 stall_id,
    output logic                 kill_id,
    output logic [NSRC*SELW-1:0] fwd_sel_x,
    output logic [DEPTH-1:0]     stage_we
);

    localparam int c_KILL_W = 2;

    // Scoreboard: bit/slice k-1 holds entry e[k]; e[1] is the instruction in X
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_we;
    logic [DEPTH-1:0]      r_load;
    logic [DEPTH*RA_W-1:0] r_rd;
    logic [c_KILL_W-1:0]   r_kill_cnt;
    logic [NSRC*SELW-1:0]  r_fwd_sel;
    logic [DEPTH-1:0]      r_stage_we;

    logic [NSRC-1:0]       w_hit;
    logic [NSRC-1:0]       w_ld;
    logic [NSRC*SELW-1:0]  w_idx;
    logic [NSRC*SELW-1:0]  w_sel;
    logic                  w_load_use;
    logic                  w_kill;
    logic                  w_stall;
    logic                  w_issue;
    logic [DEPTH-1:0]      w_rd_nz;
    logic [DEPTH-1:0]      w_stage_we_nxt;
    sb_flags_t             w_issue_flags;

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            hazard_ctrl_fwd_match #(
                .DEPTH (DEPTH),
                .RA_W  (RA_W),
                .SELW  (SELW)
            ) u_match (
                .rs       (id_rs[i*RA_W +: RA_W]),
                .used     (id_rs_used[i]),
                .sb_valid (r_valid),
                .sb_we    (r_we),
                .sb_load  (r_load),
                .sb_rd    (r_rd),
                .hit      (w_hit[i]),
                .idx      (w_idx[i*SELW +: SELW]),
                .is_load  (w_ld[i])
            );
        end
    endgenerate

    always_comb begin
        w_load_use = 1'b0;
        w_sel      = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_sel[i*SELW +: SELW] = SELW'(fwd_sel_of(w_hit[i],
                                                     32'(w_idx[i*SELW +: SELW]),
                                                     DEPTH));
            // Load data is not yet available if the load would sit short of LOAD_STAGE
            if (w_hit[i] && w_ld[i] &&
                ((32'(w_idx[i*SELW +: SELW]) + 32'd1) < 32'(LOAD_STAGE))) begin
                w_load_use = 1'b1;
            end
        end
    end

    // Kill outranks load-use so a squashed instruction never stalls the front end
    assign w_kill  = (redirect & ~stall_ext) | (r_kill_cnt != '0);
    assign w_stall = ~stall_ext & ~w_kill & id_valid & w_load_use;
    assign w_issue = id_valid & ~w_stall & ~w_kill;

    always_comb begin
        w_issue_flags.valid   = w_issue;
        w_issue_flags.we      = w_issue & id_we;
        w_issue_flags.is_load = w_issue & id_is_load;
        for (int k = 0; k < DEPTH; k++) begin
            w_rd_nz[k] = (r_rd[k*RA_W +: RA_W] != '0);
        end
        w_stage_we_nxt = {r_valid[DEPTH-2:0] & r_we[DEPTH-2:0] & w_rd_nz[DEPTH-2:0],
                          w_issue_flags.we & (id_rd != '0)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= '0;
            r_we       <= '0;
            r_load     <= '0;
            r_rd       <= '0;
            r_kill_cnt <= '0;
            r_fwd_sel  <= '0;
            r_stage_we <= '0;
        end else if (!stall_ext) begin
            r_valid    <= {r_valid[DEPTH-2:0], w_issue_flags.valid};
            r_we       <= {r_we[DEPTH-2:0],    w_issue_flags.we};
            r_load     <= {r_load[DEPTH-2:0],  w_issue_flags.is_load};
            r_rd       <= {r_rd[(DEPTH-1)*RA_W-1:0], id_rd};
            r_fwd_sel  <= w_issue ? w_sel : '0;
            r_stage_we <= w_stage_we_nxt;
            if (redirect) begin
                r_kill_cnt <= c_KILL_W'(KILL_CYCLES - 1);
            end else if (r_kill_cnt != '0) begin
                r_kill_cnt <= r_kill_cnt - 1'b1;
            end
        end
    end

    assign stall_id  = w_stall;
    assign kill_id   = w_kill;
    assign fwd_sel_x = r_fwd_sel;
    assign stage_we  = r_stage_we;

endmodule
`default_nettype wire
